// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection.
// Bubbles on flush, load-use and empty ID slots; holds contents while EX is stalled.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [7:0]        ctrl_id,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [DATA_W-1:0] rs1_data_id,
  input  logic [DATA_W-1:0] rs2_data_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [3:0]        funct_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              flush_ex,
  input  logic              ex_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              alusrc_ex,
  output logic              memtoreg_ex,
  output logic              regwrite_ex,
  output logic              memread_ex,
  output logic              memwrite_ex,
  output logic              branch_ex,
  output logic [1:0]        alu_op_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [DATA_W-1:0] rs1_data_ex,
  output logic [DATA_W-1:0] rs2_data_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [3:0]        funct_ex,
  output logic [REG_AW-1:0] rs1_ex,
  output logic [REG_AW-1:0] rs2_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned CTRL_W = 8;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [3:0]        funct_q, funct_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic rs1_used, rs2_used, load_use;

  // Hazard: a load in EX whose destination is read by the ID instruction.
  always_comb begin
    rs1_used = |ctrl_id;
    rs2_used = ~ctrl_id[7] | ctrl_id[3];
    load_use = valid_q & ctrl_q[4] & ctrl_q[5] & (rd_q != '0) & id_valid &
               ((rs1_used & (rs1_id == rd_q)) | (rs2_used & (rs2_id == rd_q)));
  end

  assign stall_id = ex_stall | (load_use & ~flush_ex);

  // Next-state selection in priority order: flush, stall, load-use, empty slot, capture.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (flush_ex) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (!id_valid) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d    = 1'b1;
      ctrl_d     = ctrl_id;
      pc_d       = pc_id;
      rs1_data_d = rs1_data_id;
      rs2_data_d = rs2_data_id;
      imm_d      = imm_id;
      funct_d    = funct_id;
      rs1_d      = rs1_id;
      rs2_d      = rs2_id;
      rd_d       = rd_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid = valid_q;
  assign {alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex,
          memwrite_ex, branch_ex, alu_op_ex} = ctrl_q;
  assign pc_ex       = pc_q;
  assign rs1_data_ex = rs1_data_q;
  assign rs2_data_ex = rs2_data_q;
  assign imm_ex      = imm_q;
  assign funct_ex    = funct_q;
  assign rs1_ex      = rs1_q;
  assign rs2_ex      = rs2_q;
  assign rd_ex       = rd_q;
  assign bubble_cnt  = cnt_q;

endmodule
